cpu2_core: RTL
==============

# cpu2_core

Parametrised second-generation multi-cycle processor core: a 16-bit instruction set over a configurable-width datapath, with a compare/zero flag, an immediate-load path, a halt instruction and a handshaked data-memory port. It fetches one instruction at a time from instruction memory and sequences it through a fixed state machine. It drives a separate data memory and sits at the top of the CPU playground design.

## Interface
Parameters:
- DW, 16: datapath, register and address width; legal range 8..32.
- NREG, 16: implemented registers; legal range 2..16.
- RST_PC, 0: PC value loaded at reset.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- IA  out  DW  instruction address; always equals PC.
- ID  in  16  instruction word; sampled in FETCH.
- DA  out  DW  data address.
- DOUT  out  DW  store data.
- DIN  in  DW  load data.
- RW  out  1  1 = read, 0 = write.
- DREQ  out  1  data access request.
- DRDY  in  1  data access complete.
- HALTED  out  1  core stopped.

## Operation
- Instruction fields: op[15:12], rd[11:8], ra[7:4], rb[3:0], imm8[7:0].
- Register reads with an index ≥ NREG return 0; register writes with an index ≥ NREG are dropped.
- ALU ops, all of the form rd ← f(Ra, Rb):
  - op 0..7 = ADD, SUB, SHR, SHL, OR, AND, NOT (uses Ra only), XOR.
  - All arithmetic is modulo 2^DW.
  - A shift by ≥ DW yields 0.
  - FLAG ← (result == 0).
- op 8 JMP: rd ← PC+1, then PC ← Rb.
- op 9 BRZ: if FLAG, PC ← Rb; otherwise PC ← PC+1. Nothing is written.
- op A ST: mem[Rb] ← Ra.
- op B LD: rd ← mem[Ra].
- op C LDI: rd ← zero-extended imm8.
- op D CMP: FLAG ← (Ra == Rb). No register write.
- op E HALT: enter HALT and set HALTED = 1. Only reset leaves HALT.
- op F NOP: no effect beyond PC ← PC+1.
- All non-jump/branch instructions end with PC ← PC+1, wrapping modulo 2^DW.
- State machine:
  - FETCH → DECODE → EXEC → WB → FETCH for non-memory instructions.
  - LD/ST insert MEM between EXEC and WB.
  - HALT: EXEC → HALT, and the core stays there.
- In MEM: DREQ = 1; DA = address; RW = 0 for ST (DOUT = Ra), RW = 1 for LD.
- LD data is captured from DIN on the cycle MEM exits.
- Register write, FLAG update and PC update all occur in WB only.
- Reset values:
  - PC = RST_PC, so IA = RST_PC.
  - DA = 0, DOUT = 0, RW = 1, DREQ = 0, HALTED = 0.
  - FLAG = 0; all registers = 0; state = FETCH.
- Reset asserted in any state, including mid-MEM, aborts the instruction on the next edge. The aborted instruction writes nothing.

## Timing
- Non-memory instruction: exactly 4 cycles, from the FETCH edge to the next FETCH.
- LD/ST: 4 + n cycles, where n = the number of MEM cycles (see Configuration).
- A write-back value is visible to the immediately following instruction; no hazards exist because execution is strictly sequential.
- DREQ is registered: it asserts on the edge entering MEM and deasserts on the edge leaving MEM.
- DA, DOUT and RW are held stable for the whole of MEM.
- Outside MEM: DREQ = 0, RW = 1, and DA/DOUT hold their last values.

## Configuration
- CPU2_WAIT_EN defined:
  - MEM stays until a rising edge that samples DRDY = 1; that is the exit edge, so n ≥ 1.
  - LD captures DIN on that same edge.
  - DRDY = 1 on the first MEM cycle gives n = 1.
- CPU2_WAIT_EN undefined:
  - DRDY is ignored; MEM lasts exactly one cycle (n = 1).
  - LD captures DIN at the end of that cycle.

## Structure
- Package cpu2_pkg:
  - opcode localparams (OP_ADD … OP_NOP);
  - state enum typedef (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - instruction field-slice constants.
- Sub-module cpu2_alu: combinational, parametrised by DW; takes op, a, b; returns result and zero.
- The state machine, register file and memory interface stay in cpu2_core.

## Test plan
- Reset, then LDI r1,5; LDI r2,3; SUB r3,r1,r2 → r3 = 2, FLAG = 0; each instruction takes 4 cycles; IA steps RST_PC, +1, +2.
- ADD overflow: DW = 16, r1 = 0xFFFF, r2 = 1, ADD r3,r1,r2 → r3 = 0, FLAG = 1. SHL with r2 = 16 → result 0.
- ST r4→[r5], then LD r6←[r5], with CPU2_WAIT_EN and DRDY held low 3 cycles → DREQ high for 4 cycles, RW = 0 then 1, r6 = r4, instruction takes 8 cycles.
- CMP r1,r1 then BRZ r7 with r7 = 0x20 → IA = 0x20. Repeat with unequal registers → IA = PC+1. JMP r8,r7 → r8 = old PC+1.
- NREG = 8: LDI r9,0x55 → no write; ADD r1,r9,r0 reads r9 as 0.
- HALT → HALTED = 1 and IA frozen for 20 cycles. RST_N low mid-MEM → next edge gives DREQ = 0, PC = RST_PC, target register unchanged.

Source files
------------

// File: rtl/cpu2_pkg.sv
// cpu2 shared definitions: opcodes, FSM states, instruction field positions.
package cpu2_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHR  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BRZ  = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_LDI  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  function automatic logic is_mem(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_LD);
  endfunction

  // ALU ops (0..7) and JMP share the register write path with LD and LDI.
  function automatic logic writes_rd(input logic [3:0] op);
    return (op <= OP_JMP) || (op == OP_LD) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/cpu2_alu.sv
// cpu2_alu: combinational ALU for ops 0..7; zero flags an all-zero result.
module cpu2_alu
  import cpu2_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero
);

  localparam logic [DW-1:0] DW_V = DW'(DW);

  logic big_shift;
  assign big_shift = (b >= DW_V);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_SHR: result = big_shift ? '0 : (a >> b);
      OP_SHL: result = big_shift ? '0 : (a << b);
      OP_OR:  result = a | b;
      OP_AND: result = a & b;
      OP_NOT: result = ~a;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu2_core.sv
// cpu2_core: multi-cycle core, 4 cycles per instruction, LD/ST add n MEM cycles.
// CPU2_WAIT_EN: MEM holds until DRDY is sampled high; otherwise MEM is one cycle.
module cpu2_core
  import cpu2_pkg::*;
#(
  parameter int            DW     = 16,
  parameter int            NREG   = 16,
  parameter logic [DW-1:0] RST_PC = '0
) (
  input  logic          CK,
  input  logic          RST_N,
  output logic [DW-1:0] IA,
  input  logic [15:0]   ID,
  output logic [DW-1:0] DA,
  output logic [DW-1:0] DOUT,
  input  logic [DW-1:0] DIN,
  output logic          RW,
  output logic          DREQ,
  input  logic          DRDY,
  output logic          HALTED
);

  state_t        state, state_nx;
  logic [DW-1:0] pc;
  logic [15:0]   ir;
  logic          flag, flag_q;
  logic [DW-1:0] res_q, tgt_q;
  logic [DW-1:0] regs  [NREG];
  logic [DW-1:0] rview [16];
  logic          mem_done;

  logic [3:0] op, rd, ra, rb;
  logic [7:0] imm;
  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign ra  = ir[RA_MSB:RA_LSB];
  assign rb  = ir[RB_MSB:RB_LSB];
  assign imm = ir[IMM_MSB:IMM_LSB];

  // Unimplemented register indices read as zero.
  for (genvar g = 0; g < 16; g++) begin : g_rview
    if (g < NREG) begin : g_impl
      assign rview[g] = regs[g];
    end else begin : g_zero
      assign rview[g] = '0;
    end
  end

  logic [DW-1:0] opa, opb, alu_res;
  logic          alu_zero;
  assign opa = rview[ra];
  assign opb = rview[rb];

  cpu2_alu #(.DW(DW)) u_alu (
    .op     (op),
    .a      (opa),
    .b      (opb),
    .result (alu_res),
    .zero   (alu_zero)
  );

`ifdef CPU2_WAIT_EN
  assign mem_done = DRDY;
`else
  logic unused_drdy;
  assign unused_drdy = DRDY;
  assign mem_done    = 1'b1;
`endif

  assign IA = pc;

  always_ff @(posedge CK) begin
    if (!RST_N) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC: begin
        if (op == OP_HALT)  state_nx = HALT;
        else if (is_mem(op)) state_nx = MEM;
        else                 state_nx = WB;
      end
      MEM:     if (mem_done) state_nx = WB;
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      pc     <= RST_PC;
      ir     <= '0;
      flag   <= 1'b0;
      flag_q <= 1'b0;
      res_q  <= '0;
      tgt_q  <= '0;
      DA     <= '0;
      DOUT   <= '0;
      RW     <= 1'b1;
      DREQ   <= 1'b0;
      HALTED <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: ir <= ID;
        EXEC: begin
          tgt_q <= opb;
          if (!op[3]) begin
            res_q  <= alu_res;
            flag_q <= alu_zero;
          end
          case (op)
            OP_JMP:  res_q  <= pc + 1'b1;
            OP_LDI:  res_q  <= DW'(imm);
            OP_CMP:  flag_q <= (opa == opb);
            OP_ST: begin
              DA   <= opb;
              DOUT <= opa;
              RW   <= 1'b0;
              DREQ <= 1'b1;
            end
            OP_LD: begin
              DA   <= opa;
              RW   <= 1'b1;
              DREQ <= 1'b1;
            end
            OP_HALT: HALTED <= 1'b1;
            default: ;
          endcase
        end
        MEM: begin
          if (mem_done) begin
            DREQ  <= 1'b0;
            RW    <= 1'b1;
            res_q <= DIN;
          end
        end
        // All architectural state commits here, so an aborted instruction leaves no trace.
        WB: begin
          if (writes_rd(op)) begin
            for (int i = 0; i < NREG; i++)
              if (rd == 4'(i)) regs[i] <= res_q;
          end
          if (!op[3] || op == OP_CMP) flag <= flag_q;
          case (op)
            OP_JMP:  pc <= tgt_q;
            OP_BRZ:  pc <= flag ? tgt_q : pc + 1'b1;
            default: pc <= pc + 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
